tdm_nco_sequencer: RTL and testbench
====================================

Name: tdm_nco_sequencer

Overview:
- Time-division phase-accumulator sequencer that produces the NCO address stream for the wavetable BRAM interface.
- On each sample tick it sweeps all voices round-robin, one voice per clock. Each cycle it emits one 8-bit table address, a channel-enable flag and a channel number.
- Each voice keeps its own phase accumulator, frequency tuning word (FTW) and gate, all written by the control logic.
- Output frequency of a voice: f_out = FTW * f_tick / 2^ACC_W.

Parameters:
- VOICES, 4, number of TDM voices (must equal 2^VOICES_BITS).
- VOICES_BITS, 2, width of the voice/channel index.
- ACC_W, 24, phase accumulator and FTW width.
- ADDR_W, 8, table address width; the top ADDR_W bits of the phase.

Ports:
- sys_clk  in  1  system clock (48 MHz); all logic on the rising edge.
- sys_rst_n  in  1  reset; asynchronous assert, active-low.
- sample_tick  in  1  single-cycle strobe that starts one sweep over all voices.
- ftw_wr_en  in  1  write strobe for the FTW of one voice.
- ftw_wr_voice  in  VOICES_BITS  target voice for the FTW write.
- ftw_wr_data  in  ACC_W  new FTW value.
- gate_wr_en  in  1  write strobe for the gate of one voice.
- gate_wr_voice  in  VOICES_BITS  target voice for the gate write.
- gate_wr_val  in  1  new gate value.
- nco_addr_out  out  ADDR_W  phase[ACC_W-1 -: ADDR_W] of the emitted voice.
- is_chan_en  out  1  gate of the emitted voice; 0 when no voice is emitted.
- channel_num  out  VOICES_BITS  index of the emitted voice.
- busy  out  1  sweep in progress (state SWEEP).
- sweep_done  out  1  one-cycle pulse, coincident with the last voice's emission.
- tick_overrun  out  1  one-cycle pulse: sample_tick arrived while busy and was dropped.

Behaviour:
- Reset (async, sys_rst_n=0):
  - all phase, FTW and gate registers clear to 0.
  - state returns to IDLE; slot clears to 0.
  - all outputs go to 0 immediately.
  - a sweep in progress is abandoned; no sweep_done is issued.
- FSM states: IDLE, SWEEP; slot counter is VOICES_BITS wide.
  - IDLE and sample_tick=1: on that edge, register slot 0's emission. Move to SWEEP with slot=1.
  - SWEEP: each edge registers slot k's emission and increments slot.
  - On the edge that emits slot VOICES-1: register sweep_done=1, return to IDLE, slot=0.
  - IDLE and no tick: is_chan_en=0 and sweep_done=0. nco_addr_out and channel_num hold their last values.
- Timing:
  - Outputs are registered. Voice 0 is visible the cycle after the tick edge.
  - Voices 0..VOICES-1 appear in VOICES consecutive cycles, with no gaps.
  - busy=1 exactly while state=SWEEP, i.e. VOICES-1 cycles per sweep.
- Emission of voice k:
  - nco_addr_out takes the top bits of the pre-update phase[k]; is_chan_en=gate[k]; channel_num=k.
  - On the same edge, phase[k] is updated:
    - if gate[k]=1: phase[k] <= phase[k] + ftw[k] mod 2^ACC_W (wraps silently, no saturation).
    - if gate[k]=0: phase[k] <= 0.
- Ticks:
  - A tick with busy=1 is dropped, and tick_overrun=1 is registered for one cycle.
  - A tick in the cycle where the last voice is visible (state already IDLE) is accepted, giving back-to-back sweeps with no gap.
- FTW write: ftw[v] updates on the strobe edge. If the write hits the voice being accumulated on that same edge, the accumulation uses the old FTW.
- Gate write:
  - gate[v] updates on the strobe edge.
  - Writing 0 also clears phase[v] on that edge; the clear overrides a same-edge accumulation.
  - An emission on that same edge still reports the old gate.
  - Writing 1 leaves the phase untouched.
- Simultaneous FTW and gate writes to different or identical voices are both applied independently.

Test Plan:
- Reset values: assert sys_rst_n=0 mid-sweep → all outputs 0 asynchronously. After release, state is IDLE and the first tick emits voice 0 with addr 0x00.
- Single voice ramp: ftw[0]=0x010000, gate[0]=1, 257 ticks → voice-0 addr sequence 0x00,0x01,…,0xFF,0x00. channel_num reads 0,1,2,3 in consecutive cycles of each sweep.
- Disabled voices: gate[2]=0, ftw[2]=0x123456 → slot 2 shows is_chan_en=0, addr 0x00 on every sweep. Enabling it gives addr 0x00, then 0x12, then 0x24.
- Wrap: ftw[1]=0xFFFFFF, gate[1]=1 → addr 0x00, 0xFF, 0xFF; phase after 3 accumulations = 0xFFFFFD.
- Overrun: tick, then tick 2 cycles later → one tick_overrun pulse, only 4 emissions, one sweep_done. A tick in the same cycle sweep_done is visible → next sweep emits voice 0 the following cycle.
- Collisions: write gate[0]=0 on the edge voice 0 is emitted → is_chan_en=1 shown, phase[0]=0 afterwards. An FTW write on that edge → the old FTW is used.

Source files
------------

// File: rtl/tdm_nco_sequencer.sv
// Time-division NCO sequencer: on each sample tick it sweeps every voice, one
// per clock, emitting that voice's table address and gate and advancing its phase.

module tdm_nco_voice #(
  parameter int ACC_W = 24
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             acc_en,
  input  logic             ftw_we,
  input  logic [ACC_W-1:0] ftw_d,
  input  logic             gate_we,
  input  logic             gate_d,
  output logic [ACC_W-1:0] phase,
  output logic             gate
);
  logic [ACC_W-1:0] ftw;

  // Right-hand sides see the pre-edge ftw/gate, so a same-edge write only
  // affects later accumulations; a gate-off write wins over accumulation.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase <= '0;
      ftw   <= '0;
      gate  <= 1'b0;
    end else begin
      if (ftw_we)  ftw  <= ftw_d;
      if (gate_we) gate <= gate_d;
      if (gate_we && !gate_d) phase <= '0;
      else if (acc_en)        phase <= gate ? phase + ftw : '0;
    end
  end
endmodule

module tdm_nco_sequencer #(
  parameter int VOICES      = 4,
  parameter int VOICES_BITS = 2,
  parameter int ACC_W       = 24,
  parameter int ADDR_W      = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   sample_tick,
  input  logic                   ftw_wr_en,
  input  logic [VOICES_BITS-1:0] ftw_wr_voice,
  input  logic [ACC_W-1:0]       ftw_wr_data,
  input  logic                   gate_wr_en,
  input  logic [VOICES_BITS-1:0] gate_wr_voice,
  input  logic                   gate_wr_val,
  output logic [ADDR_W-1:0]      nco_addr_out,
  output logic                   is_chan_en,
  output logic [VOICES_BITS-1:0] channel_num,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   tick_overrun
);
  localparam logic [VOICES_BITS-1:0] LAST = VOICES_BITS'(VOICES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state, state_nxt;
  logic [VOICES_BITS-1:0]  slot, slot_nxt;
  logic                    emit;

  logic [VOICES-1:0][ACC_W-1:0] phase_all;
  logic [VOICES-1:0]            gate_all;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    emit      = 1'b0;
    case (state)
      IDLE: if (sample_tick) begin
        emit      = 1'b1;
        slot_nxt  = slot + VOICES_BITS'(1);
        state_nxt = (slot == LAST) ? IDLE : SWEEP;
      end
      SWEEP: begin
        emit      = 1'b1;
        slot_nxt  = slot + VOICES_BITS'(1);
        if (slot == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    tdm_nco_voice #(.ACC_W(ACC_W)) u_voice (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .acc_en    (emit && (slot == VOICES_BITS'(i))),
      .ftw_we    (ftw_wr_en && (ftw_wr_voice == VOICES_BITS'(i))),
      .ftw_d     (ftw_wr_data),
      .gate_we   (gate_wr_en && (gate_wr_voice == VOICES_BITS'(i))),
      .gate_d    (gate_wr_val),
      .phase     (phase_all[i]),
      .gate      (gate_all[i])
    );
  end

  assign busy = (state == SWEEP);

  // Address and channel hold their last value between sweeps.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      nco_addr_out <= '0;
      is_chan_en   <= 1'b0;
      channel_num  <= '0;
      sweep_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      is_chan_en   <= emit && gate_all[slot];
      sweep_done   <= emit && (slot == LAST);
      tick_overrun <= sample_tick && (state == SWEEP);
      if (emit) begin
        nco_addr_out <= phase_all[slot][ACC_W-1 -: ADDR_W];
        channel_num  <= slot;
      end
    end
  end
endmodule

// File: tb/tb_tdm_nco_sequencer.sv
// Bench for tdm_nco_sequencer: per-cycle comparison against a sweep-level model
// plus directed scenarios with hand-computed expectations.

module tb_tdm_nco_sequencer;
  localparam int V = 4;

  logic        sys_clk, sys_rst_n;
  logic        sample_tick;
  logic        ftw_wr_en;
  logic [1:0]  ftw_wr_voice;
  logic [23:0] ftw_wr_data;
  logic        gate_wr_en;
  logic [1:0]  gate_wr_voice;
  logic        gate_wr_val;
  logic [7:0]  nco_addr_out;
  logic        is_chan_en;
  logic [1:0]  channel_num;
  logic        busy, sweep_done, tick_overrun;

  tdm_nco_sequencer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sample_tick(sample_tick),
    .ftw_wr_en(ftw_wr_en), .ftw_wr_voice(ftw_wr_voice), .ftw_wr_data(ftw_wr_data),
    .gate_wr_en(gate_wr_en), .gate_wr_voice(gate_wr_voice), .gate_wr_val(gate_wr_val),
    .nco_addr_out(nco_addr_out), .is_chan_en(is_chan_en), .channel_num(channel_num),
    .busy(busy), .sweep_done(sweep_done), .tick_overrun(tick_overrun)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: voices still owed in the current sweep, plus per-voice state.
  logic [23:0] m_phase [V];
  logic [23:0] m_ftw   [V];
  logic        m_gate  [V];
  int          rem;
  logic [7:0]  e_addr;
  logic [1:0]  e_ch;
  logic        e_en, e_done, e_ovr, e_busy;

  task automatic model_reset();
    for (int i = 0; i < V; i++) begin
      m_phase[i] = '0; m_ftw[i] = '0; m_gate[i] = 1'b0;
    end
    rem = 0; e_addr = '0; e_ch = '0;
    e_en = 1'b0; e_done = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    int v;
    e_ovr = sample_tick && (rem > 0);
    v = -1;
    if (rem > 0) begin
      v = V - rem;
      rem--;
    end else if (sample_tick) begin
      v = 0;
      rem = V - 1;
    end
    if (v >= 0) begin
      e_addr = m_phase[v][23:16];
      e_en   = m_gate[v];
      e_ch   = 2'(v);
      e_done = (v == V - 1);
      m_phase[v] = m_gate[v] ? m_phase[v] + m_ftw[v] : 24'h0;
    end else begin
      e_en   = 1'b0;
      e_done = 1'b0;
    end
    if (ftw_wr_en) m_ftw[ftw_wr_voice] = ftw_wr_data;
    if (gate_wr_en) begin
      m_gate[gate_wr_voice] = gate_wr_val;
      if (!gate_wr_val) m_phase[gate_wr_voice] = 24'h0;
    end
    e_busy = (rem > 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else            model_step();
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #2;
      if (sys_rst_n) begin
        chk("cyc_chan_en", is_chan_en, e_en);
        chk("cyc_done", sweep_done, e_done);
        chk("cyc_overrun", tick_overrun, e_ovr);
        chk("cyc_busy", busy, e_busy);
        chk("cyc_addr", nco_addr_out, e_addr);
        chk("cyc_channel", channel_num, e_ch);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] swp_addr [V];
  logic       swp_en   [V];
  logic [1:0] swp_ch   [V];
  logic       swp_done [V];

  // One sweep; leaves us at the negedge where the last voice is visible.
  task automatic sweep();
    @(negedge sys_clk);
    sample_tick = 1'b1;
    for (int k = 0; k < V; k++) begin
      @(negedge sys_clk);
      sample_tick = 1'b0;
      swp_addr[k] = nco_addr_out;
      swp_en[k]   = is_chan_en;
      swp_ch[k]   = channel_num;
      swp_done[k] = sweep_done;
    end
  endtask

  task automatic wr_ftw(input logic [1:0] v, input logic [23:0] d);
    @(negedge sys_clk);
    ftw_wr_en = 1'b1; ftw_wr_voice = v; ftw_wr_data = d;
    @(negedge sys_clk);
    ftw_wr_en = 1'b0;
  endtask

  task automatic wr_gate(input logic [1:0] v, input logic g);
    @(negedge sys_clk);
    gate_wr_en = 1'b1; gate_wr_voice = v; gate_wr_val = g;
    @(negedge sys_clk);
    gate_wr_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_addr"}, nco_addr_out, 8'h00);
    chk({tag, "_en"}, is_chan_en, 1'b0);
    chk({tag, "_ch"}, channel_num, 2'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, sweep_done, 1'b0);
    chk({tag, "_ovr"}, tick_overrun, 1'b0);
  endtask

  initial begin
    int n_ovr, n_done, n_en;
    logic [7:0] exp_a [3];
    sys_rst_n = 1'b0; sample_tick = 1'b0;
    ftw_wr_en = 1'b0; ftw_wr_voice = '0; ftw_wr_data = '0;
    gate_wr_en = 1'b0; gate_wr_voice = '0; gate_wr_val = 1'b0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Single-voice ramp: voice 0 address counts up by one per tick and wraps.
    wr_ftw(2'd0, 24'h010000);
    wr_gate(2'd0, 1'b1);
    for (int i = 0; i < 257; i++) begin
      sweep();
      chk("ramp_addr0", swp_addr[0], 32'(i & 8'hFF));
      if (i == 0) begin
        for (int k = 0; k < V; k++) chk("ramp_channel", swp_ch[k], 32'(k));
        chk("ramp_done_first", swp_done[0], 1'b0);
        chk("ramp_done_last", swp_done[V-1], 1'b1);
        chk("ramp_en0", swp_en[0], 1'b1);
      end
    end

    // Disabled voice stays at zero, then ramps once enabled.
    wr_ftw(2'd2, 24'h123456);
    sweep();
    chk("dis_en2", swp_en[2], 1'b0);
    chk("dis_addr2", swp_addr[2], 8'h00);
    wr_gate(2'd2, 1'b1);
    exp_a[0] = 8'h00; exp_a[1] = 8'h12; exp_a[2] = 8'h24;
    for (int i = 0; i < 3; i++) begin
      sweep();
      chk("en_addr2", swp_addr[2], exp_a[i]);
      chk("en_en2", swp_en[2], 1'b1);
    end

    // Wrap with the maximum tuning word.
    wr_ftw(2'd1, 24'hFFFFFF);
    wr_gate(2'd1, 1'b1);
    exp_a[0] = 8'h00; exp_a[1] = 8'hFF; exp_a[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      sweep();
      chk("wrap_addr1", swp_addr[1], exp_a[i]);
    end
    chk("wrap_phase1_model", m_phase[1], 24'hFFFFFD);

    // Overrun: second tick two cycles into the sweep is dropped.
    @(negedge sys_clk);
    sample_tick = 1'b1;
    n_ovr = 0; n_done = 0; n_en = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge sys_clk);
      n_ovr  += int'(tick_overrun);
      n_done += int'(sweep_done);
      n_en   += int'(is_chan_en);
      sample_tick = (k == 2);
    end
    chk("ovr_pulses", n_ovr, 1);
    chk("ovr_done_pulses", n_done, 1);
    chk("ovr_emissions_gated", n_en, 3);

    // Back-to-back: tick while sweep_done is visible.
    sweep();
    sample_tick = 1'b1;
    @(negedge sys_clk);
    sample_tick = 1'b0;
    chk("b2b_channel", channel_num, 2'd0);
    chk("b2b_en", is_chan_en, 1'b1);
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done", sweep_done, 1'b0);
    repeat (3) @(negedge sys_clk);

    // Gate-off on the emission edge: old gate reported, phase cleared.
    @(negedge sys_clk);
    sample_tick = 1'b1;
    gate_wr_en = 1'b1; gate_wr_voice = 2'd0; gate_wr_val = 1'b0;
    @(negedge sys_clk);
    sample_tick = 1'b0; gate_wr_en = 1'b0;
    chk("col_gate_en", is_chan_en, 1'b1);
    chk("col_gate_ch", channel_num, 2'd0);
    repeat (3) @(negedge sys_clk);
    sweep();
    chk("col_gate_after_en", swp_en[0], 1'b0);
    chk("col_gate_after_addr", swp_addr[0], 8'h00);
    chk("col_gate_phase_model", m_phase[0], 24'h0);

    // FTW write on the emission edge: old FTW used for that accumulation.
    wr_gate(2'd0, 1'b1);
    @(negedge sys_clk);
    sample_tick = 1'b1;
    ftw_wr_en = 1'b1; ftw_wr_voice = 2'd0; ftw_wr_data = 24'h200000;
    @(negedge sys_clk);
    sample_tick = 1'b0; ftw_wr_en = 1'b0;
    repeat (3) @(negedge sys_clk);
    sweep();
    chk("col_ftw_addr_a", swp_addr[0], 8'h01);
    sweep();
    chk("col_ftw_addr_b", swp_addr[0], 8'h21);

    // Simultaneous FTW and gate write to the same voice.
    @(negedge sys_clk);
    ftw_wr_en = 1'b1; ftw_wr_voice = 2'd3; ftw_wr_data = 24'h400000;
    gate_wr_en = 1'b1; gate_wr_voice = 2'd3; gate_wr_val = 1'b1;
    @(negedge sys_clk);
    ftw_wr_en = 1'b0; gate_wr_en = 1'b0;
    exp_a[0] = 8'h00; exp_a[1] = 8'h40; exp_a[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      sweep();
      chk("dual_addr3", swp_addr[3], exp_a[i]);
    end

    // Asynchronous reset mid-sweep.
    @(negedge sys_clk);
    sample_tick = 1'b1;
    @(negedge sys_clk);
    sample_tick = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    sweep();
    chk("post_rst_addr0", swp_addr[0], 8'h00);
    chk("post_rst_en0", swp_en[0], 1'b0);
    chk("post_rst_ch0", swp_ch[0], 2'd0);
    chk("post_rst_done", swp_done[V-1], 1'b1);

    repeat (2) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
